// File: rtl/track_steer.sv
// Line-following steering controller: synchronises and debounces the three track sensors,
// flags obstacles with hysteresis, and runs the HALT/FWD/LEFT/RIGHT/SEARCH/STOP motor FSM.
module track_steer #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
  parameter logic [27:0] LOST_TIMEOUT = 28'd200000000,
  parameter logic [19:0] OBST_NEAR    = 20'd3000,
  parameter logic [19:0] OBST_FAR     = 20'd3500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left_track,
  input  logic        mid_track,
  input  logic        right_track,
  input  logic [19:0] distance,
  output logic [1:0]  mode,
  output logic [1:0]  l_IN,
  output logic [1:0]  r_IN,
  output logic        obstacle,
  output logic        lost
);

  typedef enum logic [2:0] {
    S_HALT, S_FWD, S_LEFT, S_RIGHT, S_SEARCH, S_STOP
  } state_e;

  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, pat_q, pat_d, trk_q, trk_d;
  logic [15:0] cnt_q, cnt_d;
  logic        obstacle_q, obstacle_d;
  state_e      state_q, state_d;
  dir_e        last_dir_q, last_dir_d;
  logic [27:0] timer_q, timer_d;
  logic        halt_lost_q, halt_lost_d;
  logic [1:0]  mode_q, mode_d, drive_q, drive_d;
  logic        lost_q, lost_d;

  // Pattern {L,M,R} to steering state; 101 is ambiguous and keeps the current state.
  function automatic state_e pattern_next(input logic [2:0] p, input state_e cur);
    case (p)
      3'b010, 3'b111: pattern_next = S_FWD;
      3'b110, 3'b100: pattern_next = S_LEFT;
      3'b011, 3'b001: pattern_next = S_RIGHT;
      3'b000:         pattern_next = S_SEARCH;
      default:        pattern_next = cur;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sync1_d = {left_track, mid_track, right_track};
    sync2_d = sync1_q;
    pat_d   = sync2_q;
    cnt_d   = cnt_q;
    trk_d   = trk_q;
    // cnt counts consecutive cycles the synchronised pattern has been unchanged.
    if (sync2_q != pat_q) begin
      cnt_d = 16'd1;
    end else if (cnt_q < DEBOUNCE_CYC) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (cnt_d == DEBOUNCE_CYC) begin
      trk_d = sync2_q;
    end

    obstacle_d = obstacle_q;
    if (distance < OBST_NEAR) begin
      obstacle_d = 1'b1;
    end else if (distance >= OBST_FAR) begin
      obstacle_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_lost_d = halt_lost_q;
    last_dir_d  = last_dir_q;
    if (state_q == S_HALT) begin
      if (trk_q == 3'b010 && !obstacle_q) begin
        state_d     = S_FWD;
        halt_lost_d = 1'b0;
      end
    end else if (obstacle_q) begin
      state_d = S_STOP;
    end else if (state_q == S_SEARCH && timer_q == LOST_TIMEOUT - 28'd1) begin
      state_d     = S_HALT;
      halt_lost_d = 1'b1;
    end else begin
      state_d = pattern_next(trk_q, state_q);
    end

    if (state_d == S_LEFT) begin
      last_dir_d = DIR_LEFT;
    end else if (state_d == S_RIGHT) begin
      last_dir_d = DIR_RIGHT;
    end

    timer_d = (state_q == S_SEARCH && state_d == S_SEARCH) ? timer_q + 28'd1 : 28'd0;
  end

  // Outputs are registered from the current state, one cycle behind it.
  always_comb begin
    mode_d  = 2'b00;
    drive_d = 2'b00;
    lost_d  = halt_lost_q;
    case (state_q)
      S_FWD:    begin mode_d = 2'b01; drive_d = 2'b01; end
      S_LEFT:   begin mode_d = 2'b10; drive_d = 2'b01; end
      S_RIGHT:  begin mode_d = 2'b11; drive_d = 2'b01; end
      S_SEARCH: begin
        mode_d  = (last_dir_q == DIR_RIGHT) ? 2'b11 : 2'b10;
        drive_d = 2'b01;
      end
      default:  ;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      pat_q       <= 3'b000;
      trk_q       <= 3'b000;
      cnt_q       <= 16'd0;
      obstacle_q  <= 1'b0;
      state_q     <= S_HALT;
      last_dir_q  <= DIR_LEFT;
      timer_q     <= 28'd0;
      halt_lost_q <= 1'b0;
      mode_q      <= 2'b00;
      drive_q     <= 2'b00;
      lost_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pat_q       <= pat_d;
      trk_q       <= trk_d;
      cnt_q       <= cnt_d;
      obstacle_q  <= obstacle_d;
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      timer_q     <= timer_d;
      halt_lost_q <= halt_lost_d;
      mode_q      <= mode_d;
      drive_q     <= drive_d;
      lost_q      <= lost_d;
    end
  end

  assign mode     = mode_q;
  assign l_IN     = drive_q;
  assign r_IN     = drive_q;
  assign obstacle = obstacle_q;
  assign lost     = lost_q;

endmodule
